// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8-N-1 UART transmitter between NUM_REQ byte sources.
// Packets are atomic; send is held until the transmitter is seen to have loaded the byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int TOW     = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_accept,
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic                 grant_valid,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 err_timeout,
  input  logic                 clr_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    LOADED = 2'd2,
    NEXT   = 2'd3
  } state_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [TOW-1:0]     CNT_LAST = TOW'(TIMEOUT - 1);

  state_t               state_r;
  logic                 rdy_meta_r;
  logic                 rdy_sync_r;
  logic                 rdy_s;
  logic [IDW-1:0]       last_grant_r;
  logic [IDW-1:0]       grant_id_r;
  logic                 grant_valid_r;
  logic                 last_flag_r;
  logic [TOW-1:0]       cnt_r;
  logic                 tx_send_r;
  logic [7:0]           tx_data_r;
  logic [NUM_REQ-1:0]   req_accept_r;
  logic                 busy_r;
  logic                 err_r;

  logic                 win_found_s;
  logic [IDW-1:0]       win_id_s;
  logic [7:0]           win_data_s;
  logic                 win_last_s;
  logic                 own_valid_s;
  logic [7:0]           own_data_s;
  logic                 own_last_s;
  logic                 timeout_s;

  assign rdy_s = rdy_sync_r;

  // Two-flop synchroniser for the transmitter's divided-clock ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_meta_r <= 1'b0;
      rdy_sync_r <= 1'b0;
    end else begin
      rdy_meta_r <= tx_ready;
      rdy_sync_r <= rdy_meta_r;
    end
  end

  // Round-robin winner search starting just after the previous owner.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      logic [NUM_REQ-1:0] vld_shift;
      idx       = (int'(last_grant_r) + k) % NUM_REQ;
      vld_shift = req_valid >> idx;
      if (!win_found_s && vld_shift[0]) begin
        win_found_s = 1'b1;
        win_id_s    = IDW'(idx);
      end else begin
        win_found_s = win_found_s;
        win_id_s    = win_id_s;
      end
    end
  end

  // Shifts rather than variable part-selects keep index widths parameter-independent.
  always_comb begin
    logic [NUM_REQ-1:0] last_w;
    logic [NUM_REQ-1:0] vld_o;
    logic [NUM_REQ-1:0] last_o;
    win_data_s  = 8'(req_data >> (int'(win_id_s) * 8));
    last_w      = req_last >> win_id_s;
    win_last_s  = last_w[0];
    own_data_s  = 8'(req_data >> (int'(grant_id_r) * 8));
    vld_o       = req_valid >> grant_id_r;
    last_o      = req_last >> grant_id_r;
    own_valid_s = vld_o[0];
    own_last_s  = last_o[0];
  end

  assign timeout_s = (state_r == SEND) && rdy_s && (cnt_r == CNT_LAST);

  // Sticky abandon flag; a timeout in the same cycle as clr_err keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (timeout_s) begin
      err_r <= 1'b1;
    end else if (clr_err) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  // Arbitration and send/load handshake FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      last_grant_r  <= IDW'(NUM_REQ - 1);
      grant_id_r    <= '0;
      grant_valid_r <= 1'b0;
      last_flag_r   <= 1'b0;
      cnt_r         <= '0;
      tx_send_r     <= 1'b0;
      tx_data_r     <= 8'h00;
      req_accept_r  <= '0;
      busy_r        <= 1'b0;
    end else begin
      req_accept_r <= '0;
      case (state_r)
        IDLE: begin
          if (rdy_s && win_found_s) begin
            grant_id_r    <= win_id_s;
            grant_valid_r <= 1'b1;
            tx_data_r     <= win_data_s;
            last_flag_r   <= win_last_s;
            req_accept_r  <= ONE_HOT0 << win_id_s;
            cnt_r         <= '0;
            tx_send_r     <= 1'b1;
            busy_r        <= 1'b1;
            state_r       <= SEND;
          end else begin
            state_r <= IDLE;
          end
        end
        SEND: begin
          if (!rdy_s) begin
            tx_send_r <= 1'b0;
            state_r   <= LOADED;
          end else if (cnt_r == CNT_LAST) begin
            tx_send_r     <= 1'b0;
            grant_valid_r <= 1'b0;
            last_grant_r  <= grant_id_r;
            busy_r        <= 1'b0;
            state_r       <= IDLE;
          end else begin
            cnt_r <= cnt_r + TOW'(1);
          end
        end
        LOADED: begin
          // Ready returns at the stop bit, so the next byte can follow with no idle gap.
          if (rdy_s && last_flag_r) begin
            grant_valid_r <= 1'b0;
            last_grant_r  <= grant_id_r;
            busy_r        <= 1'b0;
            state_r       <= IDLE;
          end else if (rdy_s) begin
            state_r <= NEXT;
          end else begin
            state_r <= LOADED;
          end
        end
        NEXT: begin
          if (own_valid_s) begin
            tx_data_r    <= own_data_s;
            last_flag_r  <= own_last_s;
            req_accept_r <= ONE_HOT0 << grant_id_r;
            cnt_r        <= '0;
            tx_send_r    <= 1'b1;
            state_r      <= SEND;
          end else begin
            state_r <= NEXT;
          end
        end
        default: begin
          tx_send_r     <= 1'b0;
          grant_valid_r <= 1'b0;
          busy_r        <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

  assign req_accept  = req_accept_r;
  assign tx_send     = tx_send_r;
  assign tx_data     = tx_data_r;
  assign grant_valid = grant_valid_r;
  assign grant_id    = grant_id_r;
  assign busy        = busy_r;
  assign err_timeout = err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural UART, per-requester byte queues and a
// packet-level round-robin reference model.
module tb_uart_tx_arbiter;
  localparam int N    = 4;
  localparam int TO   = 16;
  localparam int BITP = 8;
  localparam int CAP  = 128;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]   req_valid, req_last, req_accept;
  logic [8*N-1:0] req_data;
  logic           tx_send, tx_ready, grant_valid, busy, err_timeout, clr_err;
  logic [7:0]     tx_data;
  logic [1:0]     grant_id;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_accept(req_accept), .tx_send(tx_send),
    .tx_data(tx_data), .tx_ready(tx_ready), .grant_valid(grant_valid),
    .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // UART model state
  int         div_cnt, phase;
  logic [7:0] shreg;
  logic       line, uart_rdy, uart_off, force_ready;
  logic [7:0] bytes_q[$];
  logic [1:0] owner_q[$];
  logic       line_q[$];

  // requester storage
  logic [7:0] mb[N][CAP];
  logic       ml[N][CAP];
  int         hd[N], tl[N];
  logic       hold[N];
  int         acc_cnt[N];
  logic [N-1:0] prev_acc;

  int bad_onehot, bad_stable, bad_drop;
  logic       prev_send;
  logic [7:0] prev_data;

  // reference model output
  int         mdl_last;
  logic [7:0] exp_b[$];
  logic [1:0] exp_o[$];

  task automatic push_byte(input int r, input logic [7:0] b, input logic l);
    mb[r][tl[r]] = b;
    ml[r][tl[r]] = l;
    tl[r]++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (hd[i] < tl[i] && !hold[i]) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = mb[i][hd[i]];
        req_last[i]       = ml[i][hd[i]];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
  endtask

  task automatic uart_tick();
    if (phase == 0 || phase == 10) begin
      if (tx_send) begin
        shreg = tx_data; phase = 1; line = 1'b0; uart_rdy = 1'b0;
        bytes_q.push_back(tx_data);
        owner_q.push_back(grant_id);
        line_q.push_back(1'b0);
      end else begin
        phase = 0;
      end
    end else if (phase <= 8) begin
      line = shreg[3'(phase - 1)];
      phase++;
      line_q.push_back(line);
    end else begin
      line = 1'b1; uart_rdy = 1'b1; phase = 10;
      line_q.push_back(1'b1);
    end
  endtask

  task automatic uart_reset();
    div_cnt = 0; phase = 0; line = 1'b1; uart_rdy = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if ($countones(req_accept) > 1) bad_onehot++;
    if ((req_accept & prev_acc) != '0) bad_onehot++;
    prev_acc = req_accept;
    for (int i = 0; i < N; i++) begin
      if (req_accept[i]) begin
        acc_cnt[i]++;
        if (hd[i] < tl[i] && !hold[i]) hd[i]++;
        else bad_onehot++;
      end
    end
    if (prev_send && tx_send && tx_data !== prev_data) bad_stable++;
    if (prev_send && !tx_send && !uart_off && !rst && (phase == 0 || phase == 10)) bad_drop++;
    prev_send = tx_send;
    prev_data = tx_data;
    if (!uart_off) begin
      div_cnt++;
      if (div_cnt == BITP) begin
        div_cnt = 0;
        uart_tick();
      end
    end
    tx_ready = force_ready | uart_rdy;
    drive();
  endtask

  // Packet-level round robin over everything queued, assuming all queued data is presented.
  task automatic build_expected();
    int ptr[N];
    int last, idx;
    bit found;
    exp_b.delete(); exp_o.delete();
    for (int i = 0; i < N; i++) ptr[i] = hd[i];
    last = mdl_last;
    do begin
      found = 1'b0;
      idx = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && ptr[(last + k) % N] < tl[(last + k) % N]) begin
          found = 1'b1;
          idx = (last + k) % N;
        end
      end
      if (found) begin
        do begin
          exp_b.push_back(mb[idx][ptr[idx]]);
          exp_o.push_back(2'(idx));
          ptr[idx]++;
        end while (!ml[idx][ptr[idx]-1] && ptr[idx] < tl[idx]);
        last = idx;
      end
    end while (found);
    mdl_last = last;
  endtask

  task automatic run_until_done(input string name, input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      step();
      n++;
      done = !busy && !tx_send && phase == 0;
      for (int i = 0; i < N; i++) if (hd[i] < tl[i]) done = 1'b0;
    end
    if (!done) begin
      total++;
      $display("FAIL %s: not idle after %0d cycles (busy=%0b phase=%0d)", name, n, busy, phase);
    end
  endtask

  task automatic clear_obs();
    bytes_q.delete(); owner_q.delete(); line_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_err = 1'b0; force_ready = 1'b0; uart_off = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0; prev_acc = '0;
    prev_send = 1'b0; prev_data = 8'h00;
    bad_onehot = 0; bad_stable = 0; bad_drop = 0;
    for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; hold[i] = 1'b0; acc_cnt[i] = 0; end
    uart_reset();
    tx_ready = 1'b1;
    mdl_last = N - 1;
    repeat (3) step();
    total++; if (tx_send !== 1'b0 || tx_data !== 8'h00) $display("FAIL reset_tx: send=%0b data=%h want 0/00", tx_send, tx_data); else passed++;
    total++; if (req_accept !== 4'b0000) $display("FAIL reset_accept: got %b want 0000", req_accept); else passed++;
    total++; if (grant_valid !== 1'b0 || grant_id !== 2'd0) $display("FAIL reset_grant: gv=%0b id=%0d want 0/0", grant_valid, grant_id); else passed++;
    total++; if (busy !== 1'b0 || err_timeout !== 1'b0) $display("FAIL reset_status: busy=%0b err=%0b want 0/0", busy, err_timeout); else passed++;
    rst = 1'b0;
    repeat (4) step();
    total++; if (busy !== 1'b0 || tx_send !== 1'b0) $display("FAIL idle_no_req: busy=%0b send=%0b want 0/0", busy, tx_send); else passed++;
  endtask

  task automatic test_single_byte();
    logic exp_line[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit ok;
    clear_obs();
    push_byte(0, 8'hA5, 1'b1);
    build_expected();
    drive();
    run_until_done("single", 2000);
    total++; if (acc_cnt[0] !== 1) $display("FAIL single_accept: got %0d pulses want 1", acc_cnt[0]); else passed++;
    ok = (line_q.size() == 10);
    for (int j = 0; j < 10 && j < line_q.size(); j++) if (line_q[j] !== exp_line[j]) ok = 1'b0;
    total++; if (!ok) $display("FAIL single_line: %0d bits, first=%0b want 0101001011", line_q.size(), line_q.size() > 0 ? line_q[0] : 1'bx); else passed++;
    total++; if (bytes_q.size() != 1 || bytes_q[0] !== 8'hA5) $display("FAIL single_byte: n=%0d want one A5", bytes_q.size()); else passed++;
    total++; if (grant_valid !== 1'b0) $display("FAIL single_release: gv=%0b want 0", grant_valid); else passed++;
  endtask

  task automatic test_round_robin();
    for (int r = 0; r < 2; r++) begin
      clear_obs();
      for (int i = 0; i < N; i++) push_byte(i, 8'(8'h10 + i), 1'b1);
      build_expected();
      drive();
      run_until_done("round_robin", 3000);
      total++; if (bytes_q.size() != exp_b.size()) $display("FAIL rr_count: got %0d want %0d", bytes_q.size(), exp_b.size()); else passed++;
      for (int j = 0; j < exp_b.size() && j < bytes_q.size(); j++) begin
        total++;
        if (bytes_q[j] !== exp_b[j] || owner_q[j] !== exp_o[j])
          $display("FAIL rr_order[%0d]: got %h/%0d want %h/%0d", j, bytes_q[j], owner_q[j], exp_b[j], exp_o[j]);
        else passed++;
      end
    end
  endtask

  task automatic test_atomic();
    clear_obs();
    push_byte(1, 8'h01, 1'b0);
    push_byte(1, 8'h02, 1'b0);
    push_byte(1, 8'h03, 1'b1);
    push_byte(2, 8'hFF, 1'b1);
    build_expected();
    drive();
    run_until_done("atomic", 3000);
    total++; if (bytes_q.size() != exp_b.size()) $display("FAIL atomic_count: got %0d want %0d", bytes_q.size(), exp_b.size()); else passed++;
    for (int j = 0; j < exp_b.size() && j < bytes_q.size(); j++) begin
      total++;
      if (bytes_q[j] !== exp_b[j] || owner_q[j] !== exp_o[j])
        $display("FAIL atomic_order[%0d]: got %h/%0d want %h/%0d", j, bytes_q[j], owner_q[j], exp_b[j], exp_o[j]);
      else passed++;
    end
  endtask

  task automatic test_starved();
    int n, a0, a1;
    clear_obs();
    push_byte(0, 8'hAA, 1'b0);
    push_byte(0, 8'hBB, 1'b1);
    push_byte(1, 8'hCC, 1'b1);
    build_expected();
    a0 = acc_cnt[0]; a1 = acc_cnt[1];
    drive();
    n = 0;
    while (acc_cnt[0] == a0 && n < 200) begin step(); n++; end
    hold[0] = 1'b1;
    drive();
    repeat (150) step();
    total++; if (busy !== 1'b1 || grant_valid !== 1'b1 || grant_id !== 2'd0) $display("FAIL starve_hold: busy=%0b gv=%0b id=%0d want 1/1/0", busy, grant_valid, grant_id); else passed++;
    total++; if (acc_cnt[1] !== a1 || tx_send !== 1'b0) $display("FAIL starve_other: acc1=%0d send=%0b want %0d/0", acc_cnt[1], tx_send, a1); else passed++;
    hold[0] = 1'b0;
    drive();
    run_until_done("starved", 3000);
    total++; if (bytes_q.size() != exp_b.size()) $display("FAIL starve_count: got %0d want %0d", bytes_q.size(), exp_b.size()); else passed++;
    for (int j = 0; j < exp_b.size() && j < bytes_q.size(); j++) begin
      total++;
      if (bytes_q[j] !== exp_b[j] || owner_q[j] !== exp_o[j])
        $display("FAIL starve_order[%0d]: got %h/%0d want %h/%0d", j, bytes_q[j], owner_q[j], exp_b[j], exp_o[j]);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    int n, hi;
    force_ready = 1'b1; uart_off = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push_byte(2, 8'(8'h77 + k), 1'b1);
      clr_err = (k == 1);
      drive();
      n = 0;
      while (!tx_send && n < 50) begin step(); n++; end
      hi = 0;
      while (tx_send && hi < 100) begin step(); hi++; end
      clr_err = 1'b0;
      total++; if (hi !== TO) $display("FAIL timeout_len[%0d]: send high %0d cycles want %0d", k, hi, TO); else passed++;
      total++; if (err_timeout !== 1'b1) $display("FAIL timeout_err[%0d]: got %0b want 1", k, err_timeout); else passed++;
      total++; if (grant_valid !== 1'b0 || busy !== 1'b0) $display("FAIL timeout_release[%0d]: gv=%0b busy=%0b want 0/0", k, grant_valid, busy); else passed++;
      if (k == 0) begin
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        total++; if (err_timeout !== 1'b0) $display("FAIL clr_err: got %0b want 0", err_timeout); else passed++;
      end
    end
    step();
    total++; if (err_timeout !== 1'b1) $display("FAIL err_sticky: got %0b want 1", err_timeout); else passed++;
    mdl_last = 2;
    force_ready = 1'b0; uart_off = 1'b0;
    uart_reset();
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    clear_obs();
    push_byte(1, 8'h5A, 1'b0);
    push_byte(1, 8'h5B, 1'b1);
    drive();
    n = 0;
    while (!tx_send && n < 50) begin step(); n++; end
    rst = 1'b1;
    #1;
    total++; if (tx_send !== 1'b0 || tx_data !== 8'h00 || req_accept !== 4'b0000) $display("FAIL rst_mid_tx: send=%0b data=%h acc=%b want 0/00/0000", tx_send, tx_data, req_accept); else passed++;
    total++; if (grant_valid !== 1'b0 || grant_id !== 2'd0 || busy !== 1'b0 || err_timeout !== 1'b0) $display("FAIL rst_mid_status: gv=%0b id=%0d busy=%0b err=%0b want 0", grant_valid, grant_id, busy, err_timeout); else passed++;
    for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; end
    drive();
    repeat (3) step();
    uart_reset();
    clear_obs();
    rst = 1'b0;
    mdl_last = N - 1;
    for (int i = 0; i < N; i++) push_byte(i, 8'($urandom_range(255)), 1'b1);
    build_expected();
    drive();
    run_until_done("reset_mid", 3000);
    total++; if (owner_q.size() == 0 || owner_q[0] !== 2'd0) $display("FAIL rst_first_owner: got %0d want 0", owner_q.size() > 0 ? owner_q[0] : 2'bxx); else passed++;
    for (int j = 0; j < exp_b.size() && j < bytes_q.size(); j++) begin
      total++;
      if (bytes_q[j] !== exp_b[j] || owner_q[j] !== exp_o[j])
        $display("FAIL rst_order[%0d]: got %h/%0d want %h/%0d", j, bytes_q[j], owner_q[j], exp_b[j], exp_o[j]);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      clear_obs();
      for (int i = 0; i < N; i++) begin
        int npk;
        npk = $urandom_range(2);
        for (int p = 0; p < npk; p++) begin
          int len;
          len = $urandom_range(3, 1);
          for (int b = 0; b < len; b++) push_byte(i, 8'($urandom_range(255)), b == len - 1);
        end
      end
      build_expected();
      drive();
      run_until_done("random", 20000);
      total++; if (bytes_q.size() != exp_b.size()) $display("FAIL rand_count[%0d]: got %0d want %0d", r, bytes_q.size(), exp_b.size()); else passed++;
      for (int j = 0; j < exp_b.size() && j < bytes_q.size(); j++) begin
        total++;
        if (bytes_q[j] !== exp_b[j] || owner_q[j] !== exp_o[j])
          $display("FAIL rand_order[%0d.%0d]: got %h/%0d want %h/%0d", r, j, bytes_q[j], owner_q[j], exp_b[j], exp_o[j]);
        else passed++;
      end
    end
    total++; if (bad_onehot !== 0) $display("FAIL accept_onehot: %0d violations want 0", bad_onehot); else passed++;
    total++; if (bad_stable !== 0) $display("FAIL data_stable: %0d violations want 0", bad_stable); else passed++;
    total++; if (bad_drop !== 0) $display("FAIL send_held: %0d early drops want 0", bad_drop); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_round_robin();
    test_atomic();
    test_starved();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one 8-N-1 UART transmitter between NUM_REQ byte requesters using round-robin arbitration.
- Packets are atomic: the grant is held until the owner's byte flagged `last` has been loaded.
- Drives the transmitter's send/data pair and watches its ready output. Handles the transmitter's slow divided-clock sampling with a hold-until-loaded handshake.
- Sits between logging/command sources and the UART TX.

Parameters:
- NUM_REQ, 4, number of requesters (1..16).
- TIMEOUT, 4096, clk cycles allowed from send assertion to observed load before the byte is abandoned. Must exceed two bit periods.
- IDW, (NUM_REQ>1 ? $clog2(NUM_REQ) : 1), grant index width (derived).
- TOW, $clog2(TIMEOUT+1), timeout counter width (derived).

Ports:
- clk, input, 1, system clock (same clock that feeds the UART's divider).
- rst, input, 1, reset, asynchronous, active-high.
- req_valid, input, NUM_REQ, requester i presents a byte.
- req_data, input, 8*NUM_REQ, byte for requester i in bits [8i+7:8i].
- req_last, input, NUM_REQ, presented byte ends requester i's packet.
- req_accept, output, NUM_REQ, one-cycle pulse: byte i captured, requester may advance.
- tx_send, output, 1, to UART send.
- tx_data, output, 8, to UART data; registered, stable while tx_send=1.
- tx_ready, input, 1, from UART ready (divided-clock domain).
- grant_valid, output, 1, a requester currently owns the UART.
- grant_id, output, IDW, current or last owner index.
- busy, output, 1, state != IDLE.
- err_timeout, output, 1, sticky; a byte was abandoned.
- clr_err, input, 1, synchronous clear of err_timeout.

Behaviour:
- tx_ready passes through a 2-flop synchroniser giving rdy_s. All decisions use rdy_s.
- States: IDLE, SEND, LOADED, NEXT.
- IDLE:
  - Transition requires rdy_s=1 and any req_valid.
  - Winner = first valid index searching from (last_grant+1) mod NUM_REQ upward, wrapping.
  - On transition: register grant_id=winner, grant_valid=1, tx_data=req_data[winner], last_flag=req_last[winner]; pulse req_accept[winner]; clear timeout counter; go SEND.
- SEND:
  - tx_send=1; counter increments each cycle.
  - rdy_s=0 (byte loaded) -> tx_send=0, go LOADED.
  - Counter reaches TIMEOUT first -> tx_send=0, err_timeout=1, grant released, last_grant=grant_id, go IDLE.
- LOADED:
  - Wait for rdy_s=1 (stop bit reached).
  - If last_flag: grant_valid=0, last_grant=grant_id, go IDLE. Arbitration happens next cycle.
  - Else go NEXT.
- NEXT:
  - Wait for req_valid[grant_id]; no timeout; other requesters stall.
  - Then capture data/last, pulse req_accept[grant_id], clear counter, go SEND.
- Back-to-back bytes: send reasserts while the UART is in STOP, so there is no idle bit between bytes.
- Latency: IDLE with valid and rdy_s=1 -> tx_send high 1 cycle later, with req_accept in the same cycle.
- req_accept is one-hot or zero. A requester holding valid high is never accepted twice for one pulse.
- Simultaneous events:
  - clr_err and a timeout in the same cycle: set wins.
  - A req_valid change in the cycle of capture is ignored; the captured value is used.
- Reset values:
  - State IDLE; tx_send=0, tx_data=8'h00, req_accept=0.
  - grant_valid=0, grant_id=0, last_grant=NUM_REQ-1 (so requester 0 wins first), busy=0, err_timeout=0, synchroniser=0.
- Reset mid-packet aborts at once; no req_accept pulse is issued.
- Constraint: the UART divider half-period must be at least 4 clk cycles, so send is held across at least one divided-clock edge.

Test Plan:
- Single byte: req 0 sends 8'hA5 with last=1 -> one req_accept[0] pulse, tx_send held until tx_ready falls, serial line shows 0,1,0,1,0,0,1,0,1,1, then grant_valid=0.
- Round-robin: all 4 valid with single-byte packets 8'h10..8'h13 -> bytes transmitted in order 10,11,12,13. Then re-request all -> order again starts at 0 (last_grant=3).
- Packet atomicity: req 1 sends 3-byte packet 8'h01,02,03 (last on 03) while req 2 is valid with 8'hFF -> line carries 01,02,03,FF. grant_id stays 1 until after 03 loads.
- Starved packet: req 0 drops valid after first non-last byte -> FSM sits in NEXT with grant held, no req_accept to others. Reasserting valid resumes.
- Timeout: tx_ready tied high, TIMEOUT=16 -> tx_send drops 16 cycles after rising, err_timeout=1, grant released; clr_err clears it.
- Reset mid-byte: assert rst while in SEND -> all outputs at reset values within the same cycle. After release, requester 0 wins first.
